// File: rtl/insn_fetch_unit_pkg.sv
// Shared widths, fetch constants and the prefetch entry type for the instruction fetch unit.
package insn_fetch_unit_pkg;

  localparam int INSN_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [INSN_WIDTH-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/insn_fetch_unit_if.sv
// Memory-side and CPU-side signals of the fetch unit; master is the fetch unit itself.
interface insn_fetch_unit_if;
  import insn_fetch_unit_pkg::*;

  logic                  imemReq;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic [INSN_WIDTH-1:0] imemRdata;
  logic                  insnValid;
  logic [INSN_WIDTH-1:0] insn;
  logic [ADDR_WIDTH-1:0] insnAddr;
  logic                  insnReady;
  logic                  redirectValid;
  logic [ADDR_WIDTH-1:0] redirectAddr;

  modport master (
    output imemReq, imemAddr, insnValid, insn, insnAddr,
    input  imemRdata, insnReady, redirectValid, redirectAddr
  );

  modport slave (
    input  imemReq, imemAddr, insnValid, insn, insnAddr,
    output imemRdata, insnReady, redirectValid, redirectAddr
  );

endinterface

// File: rtl/insn_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc, insn}; flush wins over push and pop in the same cycle.
module insn_fetch_unit_fetch_fifo
  import insn_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic             do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/insn_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited reads, and hands words to decode.
module insn_fetch_unit
  import insn_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  insn_fetch_unit_if.master   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                  resp_pending_q, resp_pending_d;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        in_flight;
  fetch_entry_t          fifo_head;
  fetch_entry_t          push_entry;
  logic                  issue;
  logic                  insn_valid;
  logic                  pop;

  always_comb begin
    // The pending response already owns a FIFO slot, so push never has to stall.
    in_flight      = {1'b0, fifo_count} + (CNT_W+1)'(resp_pending_q);
    issue          = !bus.redirectValid && (in_flight < (CNT_W+1)'(DEPTH));
    fetch_pc_d     = fetch_pc_q;
    if (bus.redirectValid) fetch_pc_d = bus.redirectAddr;
    else if (issue)        fetch_pc_d = fetch_pc_q + PC_INC;
    resp_pending_d = issue;
    resp_pc_d      = fetch_pc_q;
    insn_valid     = (fifo_count != '0);
    pop            = insn_valid && bus.insnReady;
    push_entry     = '{addr: resp_pc_q, insn: bus.imemRdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q     <= RESET_ADDR;
      resp_pending_q <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      resp_pending_q <= resp_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    resp_pc_q <= resp_pc_d;
  end

  insn_fetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (resp_pending_q),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirectValid),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  // Requests must stop the instant reset is asserted, not at the next edge.
  assign bus.imemReq   = rst && issue;
  assign bus.imemAddr  = fetch_pc_q;
  assign bus.insnValid = insn_valid;
  assign bus.insn      = insn_valid ? fifo_head.insn : '0;
  assign bus.insnAddr  = insn_valid ? fifo_head.addr : '0;

endmodule

// File: doc/insn_fetch_unit.md
Name: insn_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the CPU decode/execute logic, between the instruction memory and the consumer of `insn`. It owns the fetch PC and issues sequential reads to a synchronous instruction memory with a fixed 1-cycle latency. It buffers returned words with their PCs in a small prefetch FIFO and presents them to the CPU with a valid/ready handshake. A branch redirect from the CPU flushes the FIFO and all in-flight reads, then restarts fetch at the target.

Parameters:
INSN_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, instruction address width
PC_INC, 4, fetch PC increment per instruction (byte addressing)
RESET_ADDR, 0, first fetch address after reset
DEPTH, 4, prefetch FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
imemReq  out  1  read request to instruction memory this cycle
imemAddr  out  ADDR_WIDTH  read address; valid when imemReq=1
imemRdata  in  INSN_WIDTH  read data; valid the cycle after the matching imemReq
insnValid  out  1  FIFO head holds a valid instruction
insn  out  INSN_WIDTH  head instruction word
insnAddr  out  ADDR_WIDTH  PC of the head instruction
insnReady  in  1  consumer accepts head this cycle (pop when insnValid=1)
redirectValid  in  1  flush and restart fetch
redirectAddr  in  ADDR_WIDTH  restart address

Behaviour:
- Reset (rst=0, asynchronous): fetchPC=RESET_ADDR; FIFO empty (count=0, pointers=0); respPending=0; imemReq=0; insnValid=0; insn and insnAddr=0.
- Issue rule: imemReq = !redirectValid && (count + respPending < DEPTH). imemAddr = fetchPC. On issue, fetchPC <= fetchPC + PC_INC, modulo 2^ADDR_WIDTH (wrap, no error).
- Response tracking: respPending <= imemReq; respPC <= imemAddr. When respPending=1, imemRdata is pushed into the FIFO together with respPC at the end of that cycle.
- Credit check counts the pending response, so the FIFO never overflows. Push is never blocked.
- Latency: first request goes out in the first cycle after reset release, with address RESET_ADDR. insnValid rises 2 cycles after the request. Steady state delivers 1 insn/cycle while insnReady=1.
- Pop: when insnValid && insnReady, the head is removed at the edge. insnReady with insnValid=0 is ignored.
- Simultaneous push and pop: both happen and count is unchanged. This is legal at count=DEPTH, since push only occurs when credit was reserved.
- Outputs insnValid = (count!=0), with insn and insnAddr read from the head entry. These are driven combinationally from FIFO state only and never from imemRdata.
- Redirect (redirectValid=1 in cycle t):
  - imemReq=0 in cycle t.
  - At the edge, the FIFO is cleared, respPending is forced to 0 so the response arriving in t+1 is discarded, and fetchPC <= redirectAddr.
  - A pop requested in cycle t is ignored.
  - The first request to redirectAddr goes out in t+1, and insnValid=1 with insnAddr=redirectAddr in t+3.
- Back-to-back redirects: each one restarts the sequence; the last one wins.
- Reset mid-operation clears everything immediately. Any memory response after reset release is not captured, because respPending=0.
- No misalignment checking: redirectAddr is used as given.

Decomposition:
- Shared package/header: INSN_WIDTH, ADDR_WIDTH, PC_INC, RESET_ADDR constants.
- Sub-module fetch_fifo: synchronous FIFO of {addr, insn}.
  - Ports: push, pop, flush, count, head.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count has log2(DEPTH)+1 bits.
- The top level holds fetchPC, respPending, respPC, and the issue/credit logic.

Test Plan:
- Reset release, insnReady=1, memory returns word=addr^32'hA5A5_0000 -> imemAddr 0,4,8,... one per cycle; insnValid first high 2 cycles after release with insnAddr=0, then insnAddr increments by 4 every cycle.
- insnReady=0 held from reset -> exactly DEPTH=4 requests (0,4,8,12), then imemReq=0; count=4. Raise insnReady -> pops 0,4,8,12 in order, and fetch resumes at 16 with no gap in delivery.
- Redirect to 0x100 while FIFO holds 3 entries and one read is pending -> insnValid=0 the next cycle; pending word is discarded; next imemAddr=0x100; insnValid with insnAddr=0x100 three cycles after the redirect.
- redirectValid together with insnValid && insnReady -> no pop is counted, FIFO is cleared, and nothing from the old stream appears afterwards.
- Redirect to 0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap), and delivered insnAddr follow the same order.
- Assert rst=0 asynchronously mid-stream with a pending read -> imemReq and insnValid drop immediately; after release, fetch restarts at RESET_ADDR and the stale response is not delivered.
